// File: rtl/fuzz_round_ctrl.sv
// Per-round fuzz sequencer: testcase reload, DUT reset hold, watched run, then PASS/TIMEOUT report.
// Outputs are state-decoded or registered; the result holds until res_ready, and interrupt also tracks live cov.
module fuzz_round_ctrl #(
  parameter int unsigned     COV_W          = 30,
  parameter int unsigned     COV_SHIFT      = 19,
  parameter longint unsigned MAX_WAIT_CYCLE = 1000,
  parameter longint unsigned WATCHDOG       = 50000,
  parameter longint unsigned MAX_CYCLES     = 2000000000,
  parameter int unsigned     RESET_HOLD     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             loop,
  output logic             load_req,
  input  logic             load_ack,
  output logic             dut_reset,
  input  logic [63:0]      tohost,
  input  logic [COV_W-1:0] cov,
  output logic             interrupt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_code,
  output logic [63:0]      res_cycles,
  output logic             busy
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_REPORT} state_t;

  localparam logic [7:0]  CODE_PASS    = 8'd1;
  localparam logic [7:0]  CODE_TIMEOUT = 8'd5;
  localparam logic [31:0] HOLD_LAST    = 32'(RESET_HOLD - 1);

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_hold;
  logic [63:0]        r_cyc;
  logic [63:0]        r_stall;
  logic [63:0]        r_wdog;
  logic [COV_W-1:0]   r_pre_cov;
  logic [7:0]         r_res_code;
  logic [63:0]        r_res_cycles;
  logic [63:0]        w_thresh;
  logic               w_timeout;
  logic               w_unused_tohost;

  // Only bit 0 of tohost carries the pass flag.
  assign w_unused_tohost = ^tohost[63:1];

  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    return (v == '1) ? v : v + 64'd1;
  endfunction

  // Stall threshold scales with coverage magnitude; kept at 64 bits so it never wraps.
  assign w_thresh  = MAX_WAIT_CYCLE * (64'(cov >> COV_SHIFT) + 64'd1);
  assign w_timeout = (r_cyc > MAX_CYCLES);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)                w_next = S_LOAD;
      S_LOAD:   if (load_ack)             w_next = S_HOLD;
      S_HOLD:   if (r_hold == HOLD_LAST)  w_next = S_RUN;
      S_RUN:    if (tohost[0] || w_timeout) w_next = S_REPORT;
      S_REPORT: if (res_ready)            w_next = loop ? S_LOAD : S_IDLE;
      default:                            w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hold       <= '0;
      r_cyc        <= '0;
      r_stall      <= '0;
      r_wdog       <= '0;
      r_pre_cov    <= '0;
      r_res_code   <= '0;
      r_res_cycles <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (load_ack) begin
            r_hold    <= '0;
            r_cyc     <= '0;
            r_stall   <= '0;
            r_wdog    <= '0;
            r_pre_cov <= '0;
          end
        end
        S_HOLD: r_hold <= r_hold + 32'd1;
        S_RUN: begin
          r_cyc  <= sat_inc(r_cyc);
          r_wdog <= sat_inc(r_wdog);
          if (cov != r_pre_cov) begin
            r_stall   <= '0;
            r_pre_cov <= cov;
          end else begin
            r_stall <= sat_inc(r_stall);
          end
          // Reported count is the pre-increment value: a pass on the first RUN edge reports 0.
          if (tohost[0]) begin
            r_res_code   <= CODE_PASS;
            r_res_cycles <= r_cyc;
          end else if (w_timeout) begin
            r_res_code   <= CODE_TIMEOUT;
            r_res_cycles <= r_cyc;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_req   = (r_state == S_LOAD);
  assign dut_reset  = (r_state != S_RUN);
  assign res_valid  = (r_state == S_REPORT);
  assign busy       = (r_state != S_IDLE);
  assign interrupt  = (r_state == S_RUN) && ((r_stall >= w_thresh) || (r_wdog >= WATCHDOG));
  assign res_code   = r_res_code;
  assign res_cycles = r_res_cycles;

endmodule

// File: tb/tb_fuzz_round_ctrl.sv
// Bench for fuzz_round_ctrl: randomized rounds, expected results queued at issue and checked at the result handshake.
module tb_fuzz_round_ctrl;
  localparam int MW = 1000;
  localparam int SH = 19;
  localparam int WD = 4000;
  localparam int MC = 6000;
  localparam int RH = 4;

  logic        clock     = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic        loop      = 1'b0;
  logic        load_ack  = 1'b0;
  logic        res_ready = 1'b0;
  logic [63:0] tohost    = '0;
  logic [29:0] cov       = '0;
  logic        load_req, dut_reset, interrupt, res_valid, busy;
  logic [7:0]  res_code;
  logic [63:0] res_cycles;

  fuzz_round_ctrl #(
    .COV_W(30), .COV_SHIFT(SH), .MAX_WAIT_CYCLE(MW), .WATCHDOG(WD),
    .MAX_CYCLES(MC), .RESET_HOLD(RH)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .loop(loop),
    .load_req(load_req), .load_ack(load_ack), .dut_reset(dut_reset),
    .tohost(tohost), .cov(cov), .interrupt(interrupt),
    .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
    .res_cycles(res_cycles), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  code;
    logic [63:0] cyc;
  } res_t;

  res_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: a handshake is whatever the next rising edge will see.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset && res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: code %0d cycles %0d with nothing expected", res_code, res_cycles);
        end else begin
          res_t e;
          e = sb_q.pop_front();
          chk64("sb_code", 64'(res_code), 64'(e.code));
          chk64("sb_cycles", res_cycles, e.cyc);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_dut_reset"}, dut_reset, 1'b1);
    chk1({tag, "_load_req"}, load_req, 1'b0);
    chk1({tag, "_interrupt"}, interrupt, 1'b0);
    chk1({tag, "_res_valid"}, res_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk64({tag, "_res_code"}, 64'(res_code), 64'd0);
    chk64({tag, "_res_cycles"}, res_cycles, 64'd0);
  endtask

  // mode 0: random cov each cycle; 1: constant 0x80000 then one change at run cycle 2001; 2: toggle 5/6.
  task automatic do_round(input int pass_at, input int ack_dly, input int rdy_dly, input int mode,
                          input int abort_at, input bit need_start, input bit loop_after);
    int          end_j, hold_n, chg_j, stall_e;
    longint      thr;
    logic [29:0] last_val, nv;
    logic        exp_int;
    res_t        e;
    end_j  = (pass_at < MC + 1) ? pass_at : MC + 1;
    e.code = (pass_at <= MC + 1) ? 8'd1 : 8'd5;
    e.cyc  = 64'(end_j);
    if (abort_at < 0) sb_q.push_back(e);
    loop = loop_after;
    if (need_start) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    chk1("load_req_up", load_req, 1'b1);
    chk1("busy_load", busy, 1'b1);
    repeat (ack_dly) @(negedge clock);
    chk1("load_req_wait", load_req, 1'b1);
    load_ack = 1'b1;
    @(negedge clock);
    load_ack = 1'b0;
    chk1("load_req_drop", load_req, 1'b0);
    hold_n = 0;
    while (dut_reset && hold_n < 64) begin
      hold_n++;
      @(negedge clock);
    end
    chk64("hold_cycles", 64'(hold_n), 64'(RH));

    last_val = '0;
    chg_j    = -1;
    for (int j = 0; j <= end_j; j++) begin
      // Stall = cycles since coverage last changed; threshold scales with the cov currently presented.
      stall_e = j - chg_j - 1;
      thr     = longint'(MW) * (longint'(last_val >> SH) + 64'sd1);
      exp_int = (longint'(stall_e) >= thr) || (j >= WD);
      chk1("interrupt", interrupt, exp_int);
      if (j == abort_at) begin
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tohost = '0;
        check_reset_outputs("abort");
        return;
      end
      case (mode)
        1:       nv = (j < 2001) ? 30'h80000 : 30'h80001;
        2:       nv = j[0] ? 30'd6 : 30'd5;
        default: nv = 30'($urandom);
      endcase
      if (nv != last_val) chg_j = j;
      last_val  = nv;
      cov       = nv;
      start     = (j == 3);
      load_ack  = (j == 5);
      tohost    = {$urandom, $urandom};
      tohost[0] = (j == pass_at);
      @(negedge clock);
    end
    start    = 1'b0;
    load_ack = 1'b0;
    tohost   = '0;
    chk1("res_valid_up", res_valid, 1'b1);
    chk1("dut_reset_report", dut_reset, 1'b1);
    chk1("interrupt_report", interrupt, 1'b0);
    repeat (rdy_dly) begin
      chk1("hold_valid", res_valid, 1'b1);
      chk64("hold_code", 64'(res_code), 64'(e.code));
      chk64("hold_cycles_out", res_cycles, e.cyc);
      @(negedge clock);
    end
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    if (loop_after) begin
      chk1("loop_reload", load_req, 1'b1);
    end else begin
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_load_req", load_req, 1'b0);
      chk1("idle_dut_reset", dut_reset, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clock);
    chk1("por_idle_busy", busy, 1'b0);

    do_round(100, 3, 5, 0, -1, 1'b1, 1'b0);
    do_round(200, 1, 0, 0, 37, 1'b1, 1'b0);
    do_round(150, 0, 1, 0, -1, 1'b1, 1'b0);
    do_round(2010, 2, 2, 1, -1, 1'b1, 1'b0);
    do_round(4010, 2, 2, 2, -1, 1'b1, 1'b0);
    do_round(1000000, 1, 1, 0, -1, 1'b1, 1'b0);
    do_round(MC + 1, 1, 1, 0, -1, 1'b1, 1'b0);

    do_round(int'($urandom_range(20, 200)), 2, 1, 0, -1, 1'b1, 1'b1);
    do_round(int'($urandom_range(20, 200)), 1, 3, 0, -1, 1'b0, 1'b1);
    do_round(int'($urandom_range(20, 200)), 0, 0, 0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      do_round((r == 0) ? 0 : int'($urandom_range(1, 300)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), 0, -1, 1'b1, 1'b0);
    end

    repeat (3) @(negedge clock);
    chk64("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzz_round_ctrl.md
# fuzz_round_ctrl

Synthesizable sequencer for one fuzzing round of the SoC under test, sitting between the fuzz host and the DUT's reset, memory-load and interrupt pins. Each round it:
- requests a testcase reload;
- holds the DUT in reset;
- runs the DUT while watching `tohost` and the coverage sum;
- raises the MSIP-style interrupt when coverage stalls or the watchdog expires;
- reports PASS or TIMEOUT through a valid/ready result port.

This replaces per-round reset and clock forcing with a cycle-accurate controller that behaves the same in simulation and on FPGA.

## Interface
Parameters:
- `COV_W`, 30: width of coverage sum input.
- `COV_SHIFT`, 19: right shift of cov used to scale the stall threshold.
- `MAX_WAIT_CYCLE`, 1000: base stall threshold in cycles.
- `WATCHDOG`, 50000: cycles without pass before the interrupt is forced.
- `MAX_CYCLES`, 2000000000: round timeout in cycles.
- `RESET_HOLD`, 4: cycles DUT reset is held high (≥1).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low.
- `start`  in  1  pulse; begins a round when idle.
- `loop`  in  1  level; when high, a new round starts automatically after each result is accepted.
- `load_req`  out  1  request to reload testcase memory.
- `load_ack`  in  1  memory reload complete.
- `dut_reset`  out  1  active-high reset to the DUT.
- `tohost`  in  64  DUT tohost word; bit 0 means pass.
- `cov`  in  COV_W  DUT coverage sum.
- `interrupt`  out  1  interrupt to the DUT core.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  host accepts result.
- `res_code`  out  8  1 = PASS, 5 = TIMEOUT.
- `res_cycles`  out  64  round cycle count at completion.
- `busy`  out  1  high in any state other than IDLE.

## Operation
State machine: IDLE → LOAD → HOLD → RUN → REPORT → (LOAD if `loop`, else IDLE).

IDLE:
- `dut_reset` = 1.
- `start` = 1 → LOAD.

LOAD:
- `load_req` = 1 and `dut_reset` = 1.
- `load_ack` = 1 → HOLD. `load_req` drops in the same cycle the state changes.

HOLD:
- `dut_reset` = 1 for exactly RESET_HOLD cycles, then → RUN.
- On entry, cycle counter, stall counter, watchdog and `pre_cov` are cleared to 0.

RUN:
- `dut_reset` = 0.
- Cycle counter increments every cycle.
- Stall counter:
  - cleared and `pre_cov` ← `cov` when `cov` ≠ `pre_cov`;
  - otherwise increments.
- Watchdog increments every cycle.
- `interrupt` = (stall ≥ MAX_WAIT_CYCLE × ((cov >> COV_SHIFT) + 1)) OR (watchdog ≥ WATCHDOG).
  - Evaluated from registered counters and the current `cov`.
  - Product computed at 64 bits, with no truncation.
- `tohost[0]` = 1 → REPORT with code 1.
- Otherwise, cycle counter > MAX_CYCLES → REPORT with code 5.
- If both hold in the same cycle, PASS wins.

REPORT:
- `dut_reset` = 1 and `interrupt` = 0.
- `res_valid` = 1; `res_code` and `res_cycles` are stable until `res_valid && res_ready`.
- On handshake: → LOAD if `loop`, else IDLE.

`start` outside IDLE is ignored. `load_ack` outside LOAD is ignored.

## Timing
- Reset values (`reset` = 0 at a clock edge): state IDLE, `dut_reset` = 1, `load_req` = 0, `interrupt` = 0, `res_valid` = 0, `res_code` = 0, `res_cycles` = 0, `busy` = 0, all counters 0. Reset has priority over every other input.
- All outputs are registered or decoded from state only. None depends combinationally on `res_ready`, `load_ack` or `tohost`.
- Stage latencies:
  - `start` sampled at edge N → `load_req` = 1 from N+1.
  - `load_ack` at edge M → HOLD from M+1.
  - `dut_reset` falls at M+1+RESET_HOLD.
- `tohost[0]` sampled at edge P → `res_valid` = 1 from P+1.
- `res_cycles` = number of RUN cycles before the terminating edge; a pass on the first RUN edge reports 0.
- Stall/interrupt timing: `cov` constant from RUN entry, with cov>>19 = 0, → `interrupt` rises on the cycle the stall counter reaches 1000.
- Watchdog is not cleared by coverage changes. `interrupt` stays high until the round leaves RUN or the stall condition clears.
- Counters saturate at 2^64−1; no wrap.
- `loop` is sampled only at the REPORT handshake edge.

## Test plan
- Reset mid-RUN (cycle 37): next edge → IDLE, `dut_reset` = 1, `res_valid` = 0, all counters 0; a fresh `start` runs a normal round.
- Basic pass: `start`, `load_ack` 3 cycles later, RESET_HOLD = 4, `tohost` = 1 at RUN cycle 100 → `res_valid` with code 1, `res_cycles` = 100; `res_ready` held low 5 cycles → outputs stable until ready.
- Coverage stall: `cov` = 0x80000 (shift gives 1) held constant in RUN → `interrupt` rises exactly at stall = 2000; `cov` change → `interrupt` falls next cycle.
- Watchdog: MAX_WAIT_CYCLE = 100000, `cov` toggling every cycle → `interrupt` rises at watchdog = 50000.
- Timeout: MAX_CYCLES = 500, no pass → code 5 at `res_cycles` = 501. Second run with `tohost[0]` rising on that same cycle → code 1.
- Loop mode: `loop` = 1 across 3 rounds → `load_req` reasserts the cycle after each handshake and `start` is never needed. `loop` = 0 at the third handshake → IDLE, `busy` = 0.
